pc_sequencer: RTL

Parametrised program-counter sequencer for the CPU fetch stage. It holds the program counter and advances it on fetch. It loads absolute targets on jump, and keeps a hardware return-address stack for call and return. The instruction-memory address comes from this block; the control unit drives its one-cycle command strobes.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ret_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and command-select encoding for the program-counter sequencer.
package pc_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_VEC   = 0;

    // One-hot-free encoding of the single command that wins the priority decode
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_FETCH = 3'd1,
        CMD_REL   = 3'd2,
        CMD_JUMP  = 3'd3,
        CMD_CALL  = 3'd4,
        CMD_RET   = 3'd5
    } cmd_e;

    function automatic int depth_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack: depth counter plus entry array; push-on-full and pop-on-empty are ignored.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int DW    = depth_bits(STACK_DEPTH);
    localparam int IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IW;

    logic [DW-1:0]     depth_q, depth_d;
    logic [ADDR_W-1:0] entry_q [SLOTS];
    logic [ADDR_W-1:0] entry_d [SLOTS];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;

    assign empty  = (depth_q == '0);
    assign full   = (depth_q == DW'(STACK_DEPTH));
    assign wr_idx = IW'(depth_q);
    assign rd_idx = IW'(depth_q - 1'b1);
    assign top    = entry_q[rd_idx];

    always_comb begin
        depth_d = depth_q;
        entry_d = entry_q;
        if (push && !full) begin
            entry_d[wr_idx] = din;
            depth_d         = depth_q + 1'b1;
        end else if (pop && !empty) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entries above the depth are never read, so they need no reset
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, call/return stack and sticky stack error.
// Optional relative branch (rel/offset ports) enabled by defining PC_REL_BRANCH_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
`ifdef PC_REL_BRANCH_EN
    input  logic              rel,
    input  logic [ADDR_W-1:0] offset,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              pc_overflow,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   pc_inc;
    logic              rel_req;
    logic [ADDR_W-1:0] rel_sum;
    logic              rel_ovf;
    logic              stk_push, stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_empty, stk_full;
    cmd_e              cmd;

    assign pc_inc = {1'b0, pc_q} + (ADDR_W + 1)'(1);

`ifdef PC_REL_BRANCH_EN
    logic rel_carry;

    assign rel_req              = rel;
    assign {rel_carry, rel_sum} = {1'b0, pc_q} + {1'b0, offset};
    // Negative offset: no carry out of the unsigned add means the result went below zero
    assign rel_ovf              = offset[ADDR_W-1] ? ~rel_carry : rel_carry;
`else
    assign rel_req = 1'b0;
    assign rel_sum = '0;
    assign rel_ovf = 1'b0;
`endif

    always_comb begin
        cmd = CMD_NONE;
        if (ret) begin
            cmd = CMD_RET;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (jump) begin
            cmd = CMD_JUMP;
        end else if (rel_req) begin
            cmd = CMD_REL;
        end else if (fetch) begin
            cmd = CMD_FETCH;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        ovf_d    = 1'b0;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (cmd)
            CMD_FETCH: begin
                pc_d  = pc_inc[ADDR_W-1:0];
                ovf_d = pc_inc[ADDR_W];
            end
            CMD_REL: begin
                pc_d  = rel_sum;
                ovf_d = rel_ovf;
            end
            CMD_JUMP: begin
                pc_d = target;
            end
            CMD_CALL: begin
                if (stk_full) begin
                    err_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    pc_d     = target;
                end
            end
            CMD_RET: begin
                if (stk_empty) begin
                    err_d = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    pc_d    = stk_top;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    // Return address is pc + 1 even when it wraps; a call never pulses pc_overflow
    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc[ADDR_W-1:0]),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

    assign pc          = pc_q;
    assign pc_overflow = ovf_q;
    assign stack_err   = err_q;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;

endmodule
